// File: rtl/nibble_word_sequencer_if.sv
// nibble_word_sequencer_if: nibble input, demux select/data and word output handshake bundle.
interface nibble_word_sequencer_if;
    logic [3:0]  inNibble;
    logic        inValid;
    logic        inReady;
    logic [2:0]  outSel;
    logic [31:0] demuxData;
    logic        inClear;
    logic [31:0] outWord;
    logic        outValid;
    logic        outReady;
    logic [3:0]  outCount;
    logic        outTimeout;
    modport master (
        output inNibble, inValid, demuxData, inClear, outReady,
        input  inReady, outSel, outWord, outValid, outCount, outTimeout
    );
    // inNibble is routed straight to the external demux, so the sequencer never sees it.
    modport slave (
        input  inValid, demuxData, inClear, outReady,
        output inReady, outSel, outWord, outValid, outCount, outTimeout
    );
endinterface

// File: rtl/nibble_word_sequencer.sv
// nibble_word_sequencer: steers a 1:8 nibble demux and OR-accumulates its output into 32-bit words.
module nibble_word_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input logic                    clk,
    input logic                    resetn,
    nibble_word_sequencer_if.slave bus
);
    typedef enum logic {COLLECT, FULL} state_t;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    state_t            state, state_nx;
    logic [2:0]        count;
    logic [31:0]       acc, word;
    logic [CNT_W-1:0]  idle;
    logic              valid, tmo, accept, expire;
    assign accept = state == COLLECT && bus.inValid && !bus.inClear;
    assign expire = TIMEOUT_CYCLES > 0 && state == COLLECT && count != 3'd0 && !bus.inValid
                    && !bus.inClear && idle == IDLE_LAST;
    // Ready drops with reset asynchronously, since state alone reads COLLECT during reset.
    assign bus.inReady    = resetn && state == COLLECT;
    assign bus.outSel     = count;
    assign bus.outCount   = {1'b0, count};
    assign bus.outWord    = word;
    assign bus.outValid   = valid;
    assign bus.outTimeout = tmo;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= COLLECT;
        else         state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = bus.inClear                           ? COLLECT :
                   accept && count == 3'd7                ? FULL    :
                   state == FULL && bus.outReady          ? COLLECT : state;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            acc   <= '0;
            word  <= '0;
            idle  <= '0;
            valid <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            tmo <= 1'b0;
            if (bus.inClear) begin
                acc   <= '0;
                count <= '0;
                idle  <= '0;
                valid <= 1'b0;
            end else if (accept) begin
                idle <= '0;
                if (count == 3'd7) begin
                    word  <= acc | bus.demuxData;
                    valid <= 1'b1;
                    acc   <= '0;
                    count <= '0;
                end else begin
                    acc   <= acc | bus.demuxData;
                    count <= count + 3'd1;
                end
            end else if (expire) begin
                acc   <= '0;
                count <= '0;
                idle  <= '0;
                tmo   <= 1'b1;
            end else if (state == FULL) begin
                if (bus.outReady) valid <= 1'b0;
            end else if (TIMEOUT_CYCLES > 0 && count != 3'd0) begin
                idle <= idle + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_nibble_word_sequencer.sv
// tb_nibble_word_sequencer: directed scenario tasks with hand-computed expectations.
module tb_nibble_word_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int total = 0;
    int bad = 0;
    nibble_word_sequencer_if bus ();
    nibble_word_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );
    // Demux model: index k lands in bits [31-4k:28-4k].
    assign bus.demuxData = 32'(bus.inNibble) << (5'd28 - {bus.outSel, 2'b00});
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] nib);
        bus.inNibble = nib;
        bus.inValid  = 1'b1;
        @(posedge clk); #1;
        bus.inValid  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({bus.outWord, bus.outValid, bus.outTimeout, bus.outSel, bus.outCount, bus.inReady} !== 41'd0) begin
            bad++;
            $display("FAIL reset_outputs got word=%h v=%b t=%b sel=%0d cnt=%0d rdy=%b exp all zero",
                     bus.outWord, bus.outValid, bus.outTimeout, bus.outSel, bus.outCount, bus.inReady);
        end
        #12 resetn = 1'b1;
        tick();
        total++;
        if (bus.inReady !== 1'b1 || bus.outSel !== 3'd0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b sel=%0d exp rdy=1 sel=0", bus.inReady, bus.outSel);
        end
    endtask

    task automatic test_basic();
        logic [2:0] sel_bad;
        sel_bad = 3'd0;
        bus.outReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (bus.outSel !== 3'(k)) sel_bad = 3'd1;
            send(4'(k + 1));
        end
        total++;
        if (sel_bad !== 3'd0) begin
            bad++;
            $display("FAIL basic_sel got stepping error=%0d exp 0", sel_bad);
        end
        total++;
        if (bus.outValid !== 1'b1 || bus.outWord !== 32'h12345678 || bus.inReady !== 1'b0) begin
            bad++;
            $display("FAIL basic_word got v=%b word=%h rdy=%b exp v=1 word=12345678 rdy=0",
                     bus.outValid, bus.outWord, bus.inReady);
        end
        tick();
        total++;
        if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
            bad++;
            $display("FAIL basic_drain got v=%b rdy=%b exp v=0 rdy=1", bus.outValid, bus.inReady);
        end
    endtask

    task automatic test_backpressure();
        int hold_bad;
        hold_bad = 0;
        bus.outReady = 1'b0;
        for (int k = 0; k < 8; k++) send(4'(k + 1));
        for (int c = 0; c < 10; c++) begin
            if (bus.outWord !== 32'h12345678 || bus.inReady !== 1'b0 || bus.outValid !== 1'b1) hold_bad++;
            tick();
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL bp_hold got %0d bad cycles exp 0", hold_bad);
        end
        bus.outReady = 1'b1;
        bus.inNibble = 4'hA;
        bus.inValid  = 1'b1;
        tick();
        total++;
        if (bus.outValid !== 1'b0 || bus.outCount !== 4'd0) begin
            bad++;
            $display("FAIL bp_drain got v=%b cnt=%0d exp v=0 cnt=0", bus.outValid, bus.outCount);
        end
        tick();
        bus.inValid = 1'b0;
        total++;
        if (bus.outSel !== 3'd1 || bus.outCount !== 4'd1) begin
            bad++;
            $display("FAIL bp_accept got sel=%0d cnt=%0d exp 1/1", bus.outSel, bus.outCount);
        end
        bus.inClear = 1'b1;
        tick();
        bus.inClear = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        send(4'hF);
        send(4'hE);
        send(4'hD);
        while (n < 40) begin
            tick();
            n++;
            if (bus.outTimeout === 1'b1) break;
        end
        total++;
        if (n != 16 || bus.outCount !== 4'd0) begin
            bad++;
            $display("FAIL timeout_pulse got cycles=%0d cnt=%0d exp 16/0", n, bus.outCount);
        end
        tick();
        total++;
        if (bus.outTimeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_width got %b exp 0", bus.outTimeout);
        end
        for (int k = 0; k < 8; k++) send(4'(k));
        total++;
        if (bus.outWord !== 32'h01234567 || bus.outValid !== 1'b1) begin
            bad++;
            $display("FAIL timeout_word got %h v=%b exp 01234567 v=1", bus.outWord, bus.outValid);
        end
        tick();
    endtask

    task automatic test_clear();
        int quiet_bad;
        quiet_bad = 0;
        for (int k = 0; k < 5; k++) send(4'(k + 1));
        bus.inClear  = 1'b1;
        bus.inNibble = 4'h9;
        bus.inValid  = 1'b1;
        tick();
        bus.inClear = 1'b0;
        bus.inValid = 1'b0;
        total++;
        if (bus.outCount !== 4'd0 || bus.outValid !== 1'b0 || bus.outTimeout !== 1'b0) begin
            bad++;
            $display("FAIL clear_partial got cnt=%0d v=%b t=%b exp 0/0/0", bus.outCount, bus.outValid, bus.outTimeout);
        end
        bus.outReady = 1'b0;
        for (int k = 0; k < 8; k++) send(4'(8 - k));
        bus.inClear = 1'b1;
        tick();
        bus.inClear = 1'b0;
        bus.outReady = 1'b1;
        total++;
        if (bus.outValid !== 1'b0 || bus.outCount !== 4'd0 || bus.inReady !== 1'b1) begin
            bad++;
            $display("FAIL clear_full got v=%b cnt=%0d rdy=%b exp 0/0/1", bus.outValid, bus.outCount, bus.inReady);
        end
        for (int c = 0; c < 20; c++) begin
            if (bus.outValid !== 1'b0 || bus.outTimeout !== 1'b0) quiet_bad++;
            tick();
        end
        total++;
        if (quiet_bad != 0) begin
            bad++;
            $display("FAIL clear_quiet got %0d active cycles exp 0", quiet_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] nibs [8];
        nibs = '{4'hC, 4'hA, 4'hF, 4'hE, 4'hB, 4'hA, 4'hB, 4'hE};
        for (int k = 0; k < 4; k++) send(4'(k + 3));
        #3 resetn = 1'b0;
        #1;
        total++;
        if ({bus.outWord, bus.outValid, bus.outTimeout, bus.outSel, bus.outCount, bus.inReady} !== 41'd0) begin
            bad++;
            $display("FAIL reset_mid got word=%h v=%b t=%b sel=%0d cnt=%0d rdy=%b exp all zero",
                     bus.outWord, bus.outValid, bus.outTimeout, bus.outSel, bus.outCount, bus.inReady);
        end
        #2 resetn = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) send(nibs[k]);
        total++;
        if (bus.outWord !== 32'hCAFEBABE || bus.outValid !== 1'b1 || bus.outTimeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_word got %h v=%b t=%b exp cafebabe v=1 t=0", bus.outWord, bus.outValid, bus.outTimeout);
        end
        tick();
    endtask

    task automatic test_accept_at_expiry();
        int early;
        early = 0;
        send(4'h5);
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.outTimeout !== 1'b0) early++;
        end
        send(4'h6);
        total++;
        if (early != 0 || bus.outTimeout !== 1'b0 || bus.outCount !== 4'd2) begin
            bad++;
            $display("FAIL expiry_accept got early=%0d t=%b cnt=%0d exp 0/0/2", early, bus.outTimeout, bus.outCount);
        end
        tick();
        total++;
        if (bus.outTimeout !== 1'b0 || bus.outCount !== 4'd2) begin
            bad++;
            $display("FAIL expiry_after got t=%b cnt=%0d exp 0/2", bus.outTimeout, bus.outCount);
        end
        bus.inClear = 1'b1;
        tick();
        bus.inClear = 1'b0;
    endtask

    initial begin
        bus.inNibble = 4'h0;
        bus.inValid  = 1'b0;
        bus.inClear  = 1'b0;
        bus.outReady = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_clear();
        test_reset_mid();
        test_accept_at_expiry();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
